// File: rtl/psum_acc_och.sv
// psum_acc_och: output-channel partial-sum accumulator behind the 32-input
// adder tree. Owns the tree pipeline enable, shadows tree validity through
// its 3-register latency, and folds input-channel tiles onto a bias. Each
// finished group is offered on a valid/ready port.
// Optional feature macro: PSUM_ACC_RELU_EN (clamp negative results to 0).
module psum_acc_och #(
  parameter int PSUM_WIDTH     = 32,
  parameter int ACC_WIDTH      = 32,
  parameter int TILE_CNT_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             clear,
  input  logic        [TILE_CNT_WIDTH-1:0] cfg_tile_num,
  input  logic signed [ACC_WIDTH-1:0]      bias,
  input  logic                             in_valid,
  output logic                             in_ready,
  output logic                             pipe_en,
  input  logic signed [PSUM_WIDTH-1:0]     psum,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic signed [ACC_WIDTH-1:0]      out_data,
  output logic        [TILE_CNT_WIDTH-1:0] tile_idx,
  output logic                             busy
);

  // Validity shadow of the three tree pipeline registers.
  logic vld_p0, vld_p1, vld_p2;

  logic signed [ACC_WIDTH-1:0]      acc;
  logic        [TILE_CNT_WIDTH-1:0] n_lat;
  logic        [TILE_CNT_WIDTH-1:0] n_cfg;
  logic        [TILE_CNT_WIDTH-1:0] n_cur;
  logic                             accept;
  logic                             last;
  logic signed [ACC_WIDTH-1:0]      psum_ext;
  logic signed [ACC_WIDTH-1:0]      base;
  logic signed [ACC_WIDTH-1:0]      sum;

  // Final shaping applied only to values leaving through out_data.
  function automatic logic signed [ACC_WIDTH-1:0] post_proc(
    input logic signed [ACC_WIDTH-1:0] val
  );
`ifdef PSUM_ACC_RELU_EN
    post_proc = val[ACC_WIDTH-1] ? '0 : val;
`else
    post_proc = val;
`endif
  endfunction

  // Two's-complement add that wraps modulo 2^ACC_WIDTH.
  function automatic logic signed [ACC_WIDTH-1:0] wrap_add(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [ACC_WIDTH-1:0] b
  );
    wrap_add = a + b;
  endfunction

  // The whole tree advances whenever the output slot is free or being freed.
  assign pipe_en  = !out_valid || out_ready;
  assign in_ready = pipe_en;

  // A tree result is consumed only when it is valid and the tree moves.
  assign accept = pipe_en && vld_p2;

  // Group length: a zero configuration means one tile. The live config is
  // used on tile 0 (and latched then); later tiles use the latched copy.
  assign n_cfg = (cfg_tile_num == '0) ? TILE_CNT_WIDTH'(1) : cfg_tile_num;
  assign n_cur = (tile_idx == '0) ? n_cfg : n_lat;
  assign last  = (tile_idx == n_cur - TILE_CNT_WIDTH'(1));

  assign psum_ext = ACC_WIDTH'(psum);
  assign base     = (tile_idx == '0) ? bias : acc;
  assign sum      = wrap_add(base, psum_ext);

  assign busy = vld_p0 || vld_p1 || vld_p2 || (tile_idx != '0);

  // Validity shift register; frozen with the tree, flushed by clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (clear) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (pipe_en) begin
      vld_p0 <= in_valid;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // Accumulator, tile index and latched group length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tile_idx <= '0;
      acc      <= '0;
      n_lat    <= TILE_CNT_WIDTH'(1);
    end else if (clear) begin
      tile_idx <= '0;
      acc      <= '0;
    end else if (accept) begin
      if (tile_idx == '0) begin
        n_lat <= n_cfg;
      end
      if (last) begin
        tile_idx <= '0;
      end else begin
        acc      <= sum;
        tile_idx <= tile_idx + TILE_CNT_WIDTH'(1);
      end
    end
  end

  // Output slot: loads on group completion, drains on handshake; a reload in
  // the draining cycle keeps out_valid high for back-to-back delivery.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept && last && !clear) begin
      out_valid <= 1'b1;
      out_data  <= post_proc(sum);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_psum_acc_och.sv
// Testbench for psum_acc_och: models the 3-register adder tree, keeps a
// reference accumulator, and scoreboards every delivered group result.
module tb_psum_acc_och;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic [7:0]         cfg_tile_num;
  logic signed [31:0] bias;
  logic               in_valid;
  logic               in_ready;
  logic               pipe_en;
  logic signed [31:0] psum;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic [7:0]         tile_idx;
  logic               busy;

  // Tree model input and its three pipeline registers.
  logic signed [31:0] psum_ch = '0;
  logic signed [31:0] t0 = '0, t1 = '0, t2 = '0;

  int checks   = 0;
  int failures = 0;

  logic [31:0] exp_q[$];
  int          m_idx = 0;
  int          m_n   = 1;
  logic [31:0] m_acc = '0;

  psum_acc_och #(
    .PSUM_WIDTH(32),
    .ACC_WIDTH(32),
    .TILE_CNT_WIDTH(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .clear(clear),
    .cfg_tile_num(cfg_tile_num),
    .bias(bias),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .pipe_en(pipe_en),
    .psum(psum),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .tile_idx(tile_idx),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pipe_en) begin
      t0 <= psum_ch;
      t1 <= t0;
      t2 <= t1;
    end
  end
  assign psum = t2;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef PSUM_ACC_RELU_EN
    relu = v[31] ? 32'h0 : v;
`else
    relu = v;
`endif
  endfunction

  // Reference: fold one accepted tile into the expected group state.
  task automatic model_tile(input logic [31:0] val);
    logic [31:0] s;
    if (m_idx == 0) begin
      m_n = (cfg_tile_num == 0) ? 1 : int'(cfg_tile_num);
      s = bias + val;
    end else begin
      s = m_acc + val;
    end
    if (m_idx == m_n - 1) begin
      exp_q.push_back(relu(s));
      m_idx = 0;
    end else begin
      m_acc = s;
      m_idx++;
    end
  endtask

  task automatic model_reset();
    m_idx = 0;
    m_acc = '0;
  endtask

  // Offer one tile; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] val, input bit mdl);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    psum_ch  = val;
    for (int k = 0; k < 200 && !ok; k++) begin
      #1 ok = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    if (!ok) check("send_timeout", 64'd0, 64'd1);
    else if (mdl) model_tile(val);
  endtask

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Output monitor: every handshake pops and compares the oldest expectation.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {32'd0, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        check("out_data", {32'd0, out_data}, {32'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    time t_start;
    rst = 1'b1; clear = 1'b0; cfg_tile_num = 8'd1; bias = '0;
    in_valid = 1'b0; out_ready = 1'b1;

    // Reset values
    #2;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data",  {32'd0, out_data},  64'd0);
    check("rst_tile_idx",  {56'd0, tile_idx},  64'd0);
    check("rst_busy",      {63'd0, busy},      64'd0);
    check("rst_pipe_en",   {63'd0, pipe_en},   64'd1);
    check("rst_in_ready",  {63'd0, in_ready},  64'd1);
    @(negedge clk);
    rst = 1'b0;
    wait_cycles(2);

    // Single group N=4, bias 10, tiles 1..4 -> 20, one-cycle pulse at t+4
    cfg_tile_num = 8'd4; bias = 32'sd10;
    send(32'd1, 1); send(32'd2, 1); send(32'd3, 1); send(32'd4, 1);
    @(negedge clk); check("sg_ov_t1", {63'd0, out_valid}, 64'd0);
    @(negedge clk); check("sg_ov_t2", {63'd0, out_valid}, 64'd0);
    @(negedge clk); check("sg_ov_t3", {63'd0, out_valid}, 64'd1);
    check("sg_data", {32'd0, out_data}, 64'd20);
    @(negedge clk); check("sg_ov_t4", {63'd0, out_valid}, 64'd0);
    wait_cycles(3);

    // Negative accumulation, N=3
    cfg_tile_num = 8'd3; bias = -32'sd5;
    send(32'hFFFF_FFF0, 1); send(32'd7, 1); send(32'hFFFF_FFFE, 1);
    wait_cycles(8);

    // Wrap / sign behaviour, N=1
    cfg_tile_num = 8'd1; bias = 32'h7FFF_FFFF;
    send(32'd1, 1);
    wait_cycles(3);
`ifdef PSUM_ACC_RELU_EN
    check("wrap_data", {32'd0, out_data}, 64'h0);
`else
    check("wrap_data", {32'd0, out_data}, 64'h8000_0000);
`endif
    wait_cycles(4);

    // cfg_tile_num=0 behaves as a single-tile group
    cfg_tile_num = 8'd0; bias = 32'sd100;
    send(32'd23, 1);
    wait_cycles(6);

    // Throughput: N=2, eight back-to-back tiles in eight cycles
    cfg_tile_num = 8'd2; bias = 32'sd1;
    t_start = $time;
    for (int i = 0; i < 8; i++) send(32'(i * 3 + 1), 1);
    check("thru_cycles", 64'($time - t_start), 64'd80);
    wait_cycles(8);

    // Backpressure: N=1, five tiles, consumer stalls for six cycles
    cfg_tile_num = 8'd1; bias = '0; out_ready = 1'b0;
    send(32'd11, 1); send(32'd12, 1); send(32'd13, 1); send(32'd14, 1);
    in_valid = 1'b1; psum_ch = 32'd15;
    for (int i = 0; i < 6; i++) begin
      check("bp_pipe_en",  {63'd0, pipe_en},   64'd0);
      check("bp_out_data", {32'd0, out_data},  64'd11);
      @(negedge clk);
    end
    out_ready = 1'b1;
    send(32'd15, 1);
    wait_cycles(8);
    check("bp_drained", 64'(exp_q.size()), 64'd0);

    // Clear: two tiles accumulated, one in flight, then flush
    cfg_tile_num = 8'd4; bias = 32'sd100;
    send(32'd5, 1); send(32'd6, 1);
    wait_cycles(3);
    check("clr_idx_before", {56'd0, tile_idx}, 64'd2);
    send(32'd7, 0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_reset();
    check("clr_tile_idx", {56'd0, tile_idx}, 64'd0);
    check("clr_busy",     {63'd0, busy},     64'd0);
    wait_cycles(4);
    check("clr_no_out", {63'd0, out_valid}, 64'd0);
    send(32'd1, 1); send(32'd2, 1); send(32'd3, 1); send(32'd4, 1);
    wait_cycles(3);
    check("clr_next_group", {32'd0, out_data}, 64'd110);
    wait_cycles(3);

    // Config latch: N=3 latched at tile 0, then cfg drops to 2
    cfg_tile_num = 8'd3; bias = '0;
    send(32'd1, 1);
    wait_cycles(4);
    cfg_tile_num = 8'd2;
    send(32'd2, 1);
    wait_cycles(4);
    check("cfg_mid_idx", {56'd0, tile_idx}, 64'd2);
    send(32'd3, 1);
    wait_cycles(3);
    check("cfg_first", {32'd0, out_data}, 64'd6);
    send(32'd10, 1); send(32'd20, 1);
    wait_cycles(3);
    check("cfg_second", {32'd0, out_data}, 64'd30);
    wait_cycles(3);

    // Asynchronous reset mid-group (tile_idx=2, tile in flight)
    cfg_tile_num = 8'd4; bias = '0;
    send(32'd1, 1); send(32'd2, 1); send(32'd3, 1);
    wait_cycles(2);
    check("mid_tile_idx", {56'd0, tile_idx}, 64'd2);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_idx",  {56'd0, tile_idx}, 64'd0);
    check("mid_rst_busy", {63'd0, busy},     64'd0);
    check("mid_rst_ov",   {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    wait_cycles(2);

    // Asynchronous reset during HOLD
    cfg_tile_num = 8'd1; bias = 32'sd9; out_ready = 1'b0;
    send(32'd1, 1);
    wait_cycles(3);
    check("hold_ov",      {63'd0, out_valid}, 64'd1);
    check("hold_pipe_en", {63'd0, pipe_en},   64'd0);
    #1 rst = 1'b1;
    #1;
    check("hold_rst_ov",   {63'd0, out_valid}, 64'd0);
    check("hold_rst_data", {32'd0, out_data},  64'd0);
    check("hold_rst_pe",   {63'd0, pipe_en},   64'd1);
    check("hold_rst_busy", {63'd0, busy},      64'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    out_ready = 1'b1;
    wait_cycles(4);

    for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psum_acc_och.md
# psum_acc_och

Output-channel partial-sum accumulator on the consumer side of the 32-input-channel adder tree. Drives the tree's pipeline enable, tracks which tree outputs are valid through its 3-register latency, and accumulates successive input-channel tiles onto a bias. Presents one finished output-channel value per group on a valid/ready interface toward the output buffer. Backpressure from that interface freezes the whole tree pipeline.

## Interface
Parameters:
- PSUM_WIDTH, 32: width of the tree result `psum`, signed two's complement.
- ACC_WIDTH, 32: accumulator and output width. Must be ≥ PSUM_WIDTH.
- TILE_CNT_WIDTH, 8: width of the tile count and tile index.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush of in-flight accumulation.
- cfg_tile_num  in  TILE_CNT_WIDTH  tiles per output group; 0 is treated as 1.
- bias  in  ACC_WIDTH  signed initial value of each group.
- in_valid  in  1  the tree input `psum_ch` holds a valid tile this cycle.
- in_ready  out  1  equal to pipe_en; upstream holds its tile while this is low.
- pipe_en  out  1  enable for all three tree pipeline registers.
- psum  in  PSUM_WIDTH  tree result, valid 3 enabled cycles after the input.
- out_valid  out  1  out_data holds a finished result.
- out_ready  in  1  the consumer accepts out_data.
- out_data  out  ACC_WIDTH  finished accumulation.
- tile_idx  out  TILE_CNT_WIDTH  index of the next tile to be accumulated.
- busy  out  1  a tile is in flight or a group is partially accumulated.

## Operation
- pipe_en = !out_valid | out_ready. The pipeline advances whenever the output slot is empty or is being emptied in the same cycle.
- Valid shadow: a 3-bit shift register v[0..2].
  - When pipe_en=1: v[0]←in_valid, v[1]←v[0], v[2]←v[1].
  - When pipe_en=0: the register holds.
  - v[2]=1 qualifies psum.
- Accept condition: pipe_en & v[2]. On each accept:
  - sum = (tile_idx==0 ? bias : acc) + sign_extend(psum). Addition wraps modulo 2^ACC_WIDTH.
  - If tile_idx == N−1, where N = max(cfg_tile_num, 1) latched at tile 0:
    - out_data←sum (post-processed per Configuration)
    - out_valid←1
    - tile_idx←0
  - Otherwise: acc←sum and tile_idx←tile_idx+1.
- N is latched at tile_idx==0 acceptance. Changes to cfg_tile_num mid-group have no effect until the next group. bias is sampled only at tile 0.
- out_valid clears on out_valid & out_ready unless a new result loads in that same cycle. In that case out_valid stays 1 with the new data, which gives back-to-back throughput.
- busy = |v | (tile_idx != 0).
- clear:
  - Zeroes v, tile_idx and acc next cycle. Tiles already in the tree are discarded.
  - Does not touch out_valid/out_data, so a pending result is still delivered.
  - clear has priority over an accept in the same cycle.
- States: IDLE (busy=0, out_valid=0), ACCUM (busy=1), HOLD (out_valid=1 & !out_ready, pipeline frozen). These are implicit in v, tile_idx and out_valid; no separate state register is required.

## Timing
- Reset values:
  - out_valid=0, out_data=0, tile_idx=0, busy=0.
  - v=0, acc=0.
  - in_ready=pipe_en=1.
- Latency: a tile accepted at cycle t (in_valid & pipe_en) is consumed at cycle t+3 if no stall occurs. Its group's out_valid rises at t+4 when it is the last tile.
- Stall: cycles with pipe_en=0 add one cycle each to the latency of every in-flight tile. No tile is lost or duplicated.
- Throughput: one tile per cycle sustained when out_ready=1.
- Reset asserted mid-group or during HOLD returns all outputs to their reset values immediately (asynchronous). The group is lost.
- N=1: every accepted tile produces an output, giving out_data = bias + psum.
- tile_idx wraps only via group completion. It never exceeds N−1.

## Configuration
- Macro PSUM_ACC_RELU_EN.
  - Defined: a value with the sign bit set is replaced by 0 before it is loaded into out_data. Intermediate acc values are not clamped.
  - Undefined: out_data = sum unmodified (signed).

## Test plan
- Reset: assert rst mid-group (tile_idx=2, out_valid=1) -> out_valid=0, tile_idx=0, busy=0, pipe_en=1 in the same cycle.
- Single group: N=4, bias=10, tree results 1,2,3,4, out_ready=1 -> out_data=20, out_valid for exactly 1 cycle, 4 cycles after the last in_valid.
- Backpressure: N=1, 5 consecutive tiles, out_ready=0 for 6 cycles then 1 -> pipe_en=0 while HOLD persists; all 5 results are delivered in order with none dropped.
- Wrap/sign: ACC_WIDTH=32, bias=32'h7FFFFFFF, psum=1, N=1 -> out_data=32'h80000000 without the macro; 0 with PSUM_ACC_RELU_EN.
- Clear: N=4, two tiles accumulated plus one in flight, pulse clear -> in-flight tile discarded, next group starts at bias, tile_idx=0.
- Config latch: N=3 latched, cfg_tile_num changed to 2 after tile 0 -> output after 3 tiles; next group uses 2.
